// File: rtl/attn_pkg.sv
// Shared Q1.15 helpers and FSM state type for the attention residual streamer.
package attn_pkg;
    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Returns {sat_flag, result}; overflow shows up as disagreement of the top two sum bits.
    function automatic logic [16:0] sat_add_q15(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            sat_add_q15 = {1'b1, (s[16] ? Q15_MIN : Q15_MAX)};
        else
            sat_add_q15 = {1'b0, s[15:0]};
    endfunction
endpackage

// File: rtl/attn_residual_streamer_sat_adder.sv
// Combinational Q1.15 saturating adder, thin wrapper around sat_add_q15.
module q15_sat_adder
    import attn_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum,
    output logic        o_sat
);
    assign {o_sat, o_sum} = sat_add_q15(i_a, i_b);
endmodule

// File: rtl/attn_residual_streamer.sv
// Captures attention output and residual input on attn_done, then streams the
// saturated element-wise sum row-major over a valid/ready port.
//
// state    | meaning
// S_IDLE   | waiting for attn_done, output port idle
// S_STREAM | frame captured, presenting element (row,col) until final handshake
module attn_residual_streamer
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int E          = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_attn_done,
    input  logic [L*E*DATA_WIDTH-1:0]        i_attn_out,
    input  logic [L*E*DATA_WIDTH-1:0]        i_x_in,
    output logic                             o_m_valid,
    input  logic                             i_m_ready,
    output logic [DATA_WIDTH-1:0]            o_m_data,
    output logic [$clog2(L)-1:0]             o_m_token,
    output logic                             o_m_last,
    output logic                             o_m_frame_end,
    output logic                             o_busy,
    output logic                             o_frame_done,
    output logic                             o_overrun,
    output logic [$clog2(L*E+1)-1:0]         o_sat_count
);
    localparam int NB    = L * E;
    localparam int ROW_W = $clog2(L);
    localparam int COL_W = $clog2(E);
    localparam int IDX_W = $clog2(NB);
    localparam int SC_W  = $clog2(NB + 1);

    state_t                   r_state, w_state_nxt;
    logic [ROW_W-1:0]         r_row, w_row_nxt;
    logic [COL_W-1:0]         r_col, w_col_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [NB*DATA_WIDTH-1:0] r_x_buf, r_attn_buf;
    logic [DATA_WIDTH-1:0]    r_m_data, w_op_x, w_op_attn, w_sum;
    logic                     w_sat;
    logic [SC_W-1:0]          r_sat_count;
    logic                     r_frame_done, r_overrun;
    logic                     w_streaming, w_hs, w_final, w_capture, w_overrun_evt;

    assign w_streaming   = (r_state == S_STREAM);
    assign w_hs          = w_streaming && i_m_ready;
    assign w_final       = w_hs && (r_row == ROW_W'(L-1)) && (r_col == COL_W'(E-1));
    assign w_capture     = i_attn_done && (!w_streaming || w_final);
    assign w_overrun_evt = i_attn_done && w_streaming && !w_final;

    always_comb begin
        w_col_nxt = r_col + 1'b1;
        w_row_nxt = r_row;
        if (r_col == COL_W'(E-1)) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == ROW_W'(L-1)) ? '0 : r_row + 1'b1;
        end
    end

    assign w_idx_nxt = IDX_W'(w_row_nxt) * IDX_W'(E) + IDX_W'(w_col_nxt);

    // On capture the buffers are not loaded yet, so element 0 comes straight from the inputs.
    assign w_op_x    = w_capture ? i_x_in[DATA_WIDTH-1:0]
                                 : r_x_buf[w_idx_nxt*DATA_WIDTH +: DATA_WIDTH];
    assign w_op_attn = w_capture ? i_attn_out[DATA_WIDTH-1:0]
                                 : r_attn_buf[w_idx_nxt*DATA_WIDTH +: DATA_WIDTH];

    q15_sat_adder u_sat_adder (
        .i_a   (w_op_x),
        .i_b   (w_op_attn),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_attn_done) w_state_nxt = S_STREAM;
            S_STREAM: if (w_final && !i_attn_done) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_x_buf    <= i_x_in;
            r_attn_buf <= i_attn_out;
        end
    end

    // The sum for the next element is registered on the handshake that exposes it,
    // so each element is computed (and counted) exactly once regardless of stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_m_data     <= '0;
            r_sat_count  <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_final;
            if (w_overrun_evt) r_overrun <= 1'b1;
            if (w_capture) begin
                r_row       <= '0;
                r_col       <= '0;
                r_m_data    <= w_sum;
                r_sat_count <= SC_W'(w_sat);
            end else if (w_hs) begin
                r_row <= w_row_nxt;
                r_col <= w_col_nxt;
                if (!w_final) begin
                    r_m_data    <= w_sum;
                    r_sat_count <= r_sat_count + SC_W'(w_sat);
                end
            end
        end
    end

    assign o_m_valid     = w_streaming;
    assign o_busy        = w_streaming;
    assign o_m_data      = r_m_data;
    assign o_m_token     = r_row;
    assign o_m_last      = w_streaming && (r_col == COL_W'(E-1));
    assign o_m_frame_end = o_m_last && (r_row == ROW_W'(L-1));
    assign o_frame_done  = r_frame_done;
    assign o_overrun     = r_overrun;
    assign o_sat_count   = r_sat_count;
endmodule
